// File: rtl/instr_fetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer_pkg
// Shared definitions for the instruction fetch buffer:
//   - fetch_state_e : issue-control FSM encoding (IDLE = no issue, FETCH = issue)
//   - fetch_entry_t : one prefetched instruction record {pc, data} at the
//                     default geometry (9-bit word address, 16-bit word)
// No ports (package).
// -----------------------------------------------------------------------------
package instr_fetch_buffer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    localparam int unsigned IFB_ADDR_W = 9;
    localparam int unsigned IFB_DATA_W = 16;

    // The pc sits in the upper bits so a packed entry reads as {pc, data}.
    typedef struct packed {
        logic [IFB_ADDR_W-1:0] pc;
        logic [IFB_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage : instr_fetch_buffer_pkg

// File: rtl/instr_fetch_buffer_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small circular buffer holding prefetched instruction entries.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr            : synchronous clear (empties the buffer, has priority)
//   push/push_data : write one entry at the tail
//   pop            : drop the head entry
//   head_data      : current head entry (meaningless while count == 0)
//   count          : number of valid entries, 0..DEPTH
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 25
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Next pointer/count values; clear wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; entries are reset so the head never shows X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !clr) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule : fetch_fifo

// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
// Prefetches sequential instruction words from a synchronous instruction
// memory (one-cycle read latency) into a DEPTH-entry buffer and presents them
// to a consumer with a valid/ready handshake. A one-cycle redirect flushes the
// buffer and any in-flight read and restarts fetching at redirect_pc.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   fetch_en          : permits new memory reads while high
//   redirect          : one-cycle flush-and-jump request
//   redirect_pc       : jump target, sampled while redirect = 1
//   mem_en, mem_addr  : read strobe and word address to instruction memory
//   mem_rdata         : read data, valid the cycle after mem_en
//   instr_valid       : buffer head holds an instruction
//   instr_ready       : consumer accepts the head
//   instr_data        : head instruction word
//   instr_pc          : word address of the head instruction
// -----------------------------------------------------------------------------
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 9,
    parameter int unsigned          DATA_W   = 16,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [DATA_W-1:0]   instr_data,
    output logic [ADDR_W-1:0]   instr_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    // Same {pc, data} layout as fetch_entry_t, sized by this instance.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]   fifo_count_s;
    logic               credit_ok_s;
    logic               mem_en_s;
    logic               valid_s;
    logic               push_s;
    logic               pop_s;
    entry_t             push_entry_s;
    entry_t             head_entry_s;

    // Issue/handshake decode. The credit check counts the in-flight read so
    // a word can never arrive into a full buffer.
    always_comb begin
        credit_ok_s = ({1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_C;
        mem_en_s    = (state_q == ST_FETCH) & ~redirect & credit_ok_s;
        valid_s     = (fifo_count_s != {CNT_W{1'b0}}) & ~redirect;
        pop_s       = valid_s & instr_ready;
        push_s      = inflight_q & ~redirect;
        push_entry_s.pc   = inflight_pc_q;
        push_entry_s.data = mem_rdata;
    end

    // Next-state logic for FSM, fetch pointer and in-flight tag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_en) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (fetch_en) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // mem_en is already low during redirect, so the redirect branch
        // alone decides the new fetch address.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (mem_en_s) begin
            fetch_pc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        // A read issued this cycle returns next cycle; remember its address.
        inflight_d = mem_en_s;
        if (mem_en_s) begin
            inflight_pc_d = fetch_pc_q;
        end else begin
            inflight_pc_d = inflight_pc_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {ADDR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (redirect),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .count     (fifo_count_s)
    );

    assign mem_en      = mem_en_s;
    assign mem_addr    = fetch_pc_q;
    assign instr_valid = valid_s;
    assign instr_data  = head_entry_s.data;
    assign instr_pc    = head_entry_s.pc;

endmodule : instr_fetch_buffer

// File: tb/tb_instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_buffer
// Drives the fetch buffer against a behavioural instruction memory
// (word = addr + 0x100, one-cycle latency). The reference model is the
// architectural instruction stream: consecutive word addresses starting at
// RESET_PC, restarting at redirect_pc on a redirect and at RESET_PC on reset.
// Expected {pc, data} pairs are queued from that model; a monitor pops and
// compares one entry for every accepted instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch_buffer;

    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned DEPTH    = 4;
    localparam logic [8:0]  RESET_PC = 9'h000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch_en = 1'b0;
    logic              redirect = 1'b0;
    logic [8:0]        redirect_pc = 9'h000;
    logic              mem_en;
    logic [8:0]        mem_addr;
    logic [15:0]       mem_rdata = 16'h0000;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [15:0]       instr_data;
    logic [8:0]        instr_pc;

    int n_checks = 0;
    int n_fails  = 0;
    int n_accept = 0;

    logic [8:0] model_pc = RESET_PC;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_buffer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc)
    );

    // Synchronous instruction memory: word at address a is a + 0x100.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= 16'(mem_addr) + 16'h0100;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!instr_valid && i < 10) begin
            step(1);
            i++;
        end
        check(name, 32'(instr_valid), 32'd1);
    endtask

    // Scoreboard monitor: samples the handshake on the falling edge, i.e.
    // the values that the next rising edge acts on.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_pc = RESET_PC;
            end else if (redirect) begin
                check("valid_during_redirect", 32'(instr_valid), 32'd0);
                exp_q.delete();
                model_pc = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                while (exp_q.size() < 4) begin
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 9'd1;
                end
                e = exp_q.pop_front();
                check("sb_pc", 32'(instr_pc), 32'(e));
                check("sb_data", 32'(instr_data), 32'(16'(e) + 16'h0100));
                n_accept++;
            end
        end
    end

    initial begin
        int v;
        int k;
        logic [8:0] wrap_pcs [4];
        wrap_pcs[0] = 9'h1FE;
        wrap_pcs[1] = 9'h1FF;
        wrap_pcs[2] = 9'h000;
        wrap_pcs[3] = 9'h001;

        // Reset state.
        step(3);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);

        // Start-up latency and sustained throughput.
        rst_n = 1'b1;
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        step(1);
        check("start_mem_en", 32'(mem_en), 32'd1);
        check("start_mem_addr", 32'(mem_addr), 32'(RESET_PC));
        check("start_valid_c1", 32'(instr_valid), 32'd0);
        step(1);
        check("start_valid_c2", 32'(instr_valid), 32'd0);
        check("start_mem_addr2", 32'(mem_addr), 32'(RESET_PC + 9'd1));
        step(1);
        check("start_valid_c3", 32'(instr_valid), 32'd1);
        check("start_pc", 32'(instr_pc), 32'(RESET_PC));
        check("start_data", 32'(instr_data), 32'h0100);
        v = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (instr_valid) v++;
        end
        check("throughput", 32'(v), 32'd20);

        // Consumer stall: buffer fills to DEPTH and issue stops.
        instr_ready = 1'b0;
        step(10);
        check("stall_mem_en", 32'(mem_en), 32'd0);
        check("stall_valid", 32'(instr_valid), 32'd1);
        fetch_en = 1'b0;
        instr_ready = 1'b1;
        k = 0;
        while (instr_valid && k < 20) begin
            k++;
            step(1);
        end
        check("stall_depth", 32'(k), 32'(DEPTH));
        check("drained_mem_en", 32'(mem_en), 32'd0);
        fetch_en = 1'b1;
        step(8);

        // fetch_en dropped for 5 cycles mid-stream.
        fetch_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("drop_mem_en", 32'(mem_en), 32'd0);
        end
        fetch_en = 1'b1;
        step(8);

        // Redirect with three entries buffered and one in flight.
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        fetch_en = 1'b1;
        instr_ready = 1'b0;
        step(5);
        check("pre_redirect_mem_en", 32'(mem_en), 32'd0);
        check("pre_redirect_valid", 32'(instr_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 9'h1F0;
        #1;
        check("redirect_mem_en", 32'(mem_en), 32'd0);
        check("redirect_valid", 32'(instr_valid), 32'd0);
        step(1);
        redirect = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("post_redirect_addr", 32'(mem_addr), 32'h1F0);
        wait_valid("post_redirect_valid");
        check("post_redirect_pc", 32'(instr_pc), 32'h1F0);
        step(10);

        // Address wrap from the top of the address space.
        redirect = 1'b1;
        redirect_pc = 9'h1FE;
        step(1);
        redirect = 1'b0;
        wait_valid("wrap_valid");
        for (int i = 0; i < 4; i++) begin
            check("wrap_pc", 32'(instr_pc), 32'(wrap_pcs[i]));
            step(1);
        end
        step(4);

        // Asynchronous reset pulse mid-stream.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_en", 32'(mem_en), 32'd0);
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        step(1);
        rst_n = 1'b1;
        check("after_rst_valid", 32'(instr_valid), 32'd0);
        step(1);
        check("restart_mem_en", 32'(mem_en), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'(RESET_PC));
        step(1);
        check("restart_no_push", 32'(instr_valid), 32'd0);
        step(6);

        // Randomised traffic: stalls, issue gaps and redirects.
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            fetch_en    = ($urandom_range(0, 7) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 9'($urandom());
            step(1);
        end
        redirect = 1'b0;
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        step(1);
        wait_valid("final_live");
        step(6);
        check("accepts_seen", 32'(n_accept > 150), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_instr_fetch_buffer

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 Parameter ADDR_W, default 9, instruction-memory word-address width.
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 Parameter DEPTH, default 4, prefetch buffer entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 fetch_en  in  1  permits fetch issue while high.
REQ-008 redirect  in  1  one-cycle flush-and-jump request.
REQ-009 redirect_pc  in  ADDR_W  jump target, sampled when redirect=1.
REQ-010 mem_en  out  1  read strobe to synchronous instruction memory.
REQ-011 mem_addr  out  ADDR_W  read address.
REQ-012 mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_en=1.
REQ-013 instr_valid  out  1  buffer head holds a valid instruction.
REQ-014 instr_ready  in  1  consumer accepts the head.
REQ-015 instr_data  out  DATA_W  head instruction.
REQ-016 instr_pc  out  ADDR_W  address of the head instruction.

Function
REQ-017 FSM states: IDLE (no issue) and FETCH (issue allowed); IDLE->FETCH when fetch_en=1; FETCH->IDLE when fetch_en=0; redirect does not change state.
REQ-018 mem_en = (state==FETCH) & ~redirect & (count + inflight < DEPTH); mem_addr = fetch_pc.
REQ-019 fetch_pc increments by 1 on each mem_en cycle and wraps from 2^ADDR_W-1 to 0.
REQ-020 inflight is a 1-bit flag that is set on a mem_en cycle; it marks data arriving next cycle.
REQ-021 When inflight=1 and no redirect, {mem_rdata, tagged pc} is pushed into the buffer in that cycle.
REQ-022 Pop occurs when instr_valid & instr_ready; instr_valid = (count!=0) & ~redirect.
REQ-023 Simultaneous push and pop keep count unchanged; the credit rule in REQ-018 guarantees no push when full.
REQ-024 Redirect cycle: buffer cleared (count=0), inflight data discarded, fetch_pc <= redirect_pc, no issue and no pop; fetching resumes the next cycle when in FETCH.
REQ-025 Redirect while in IDLE updates fetch_pc and clears the buffer only.
REQ-026 fetch_en=0 stops new issue; data already in flight is still pushed, and buffered entries remain poppable.
REQ-027 Sustained throughput is one instruction per cycle with the consumer always ready; first instr_valid occurs 2 cycles after the first mem_en.
REQ-028 Outputs instr_data and instr_pc are driven from the buffer head; they are don't-care when instr_valid=0.

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, mem_en=0, instr_valid=0.
REQ-030 Reset asserted mid-operation discards all buffered and in-flight data; no push occurs in the first cycle after deassertion.

Structure
REQ-031 A shared package holds the FSM state encoding (IDLE, FETCH) and a fetch-entry record {pc, data}.
REQ-032 One sub-module, fetch_fifo (DEPTH x (ADDR_W+DATA_W), with synchronous clear and count output), is instantiated once.
REQ-033 The instruction memory itself lies outside this block and is reached only through the mem_* ports.

Verification
REQ-034 Reset, fetch_en=1, ready=1, memory word = addr+0x100: instr_pc sequence 0,1,2,... with instr_data 0x100,0x101,..., one instruction per cycle from cycle 3.
REQ-035 ready=0 for 10 cycles: exactly DEPTH=4 entries are buffered and mem_en is low once full; after release pcs continue without gap or duplicate.
REQ-036 redirect with redirect_pc=0x1F0 while 3 entries are buffered and one is in flight: next valid instr_pc=0x1F0, and no stale pc appears.
REQ-037 Start at RESET_PC=0x1FE with ADDR_W=9: pcs 0x1FE,0x1FF,0x000,0x001 (wrap).
REQ-038 fetch_en dropped for 5 cycles mid-stream: the in-flight word is delivered, mem_en stays low, and fetching resumes at the next sequential pc.
REQ-039 rst_n pulsed low mid-stream: instr_valid and mem_en go low immediately, and fetch restarts at RESET_PC.
